// File: rtl/user_wb_mailbox_pkg.sv
// Shared constants for the Wishbone mailbox: register offsets, CTRL/STATUS bit
// positions and the register-select decode used by the top level.
package user_wb_mailbox_pkg;

  localparam int DATA_W = 32;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_TXDATA  = 8'h08;
  localparam logic [7:0] OFF_RXDATA  = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH = 8'h10;

  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;
  localparam int CTRL_TX_FLUSH  = 2;
  localparam int CTRL_RX_FLUSH  = 3;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UNF   = 5;
  localparam int ST_RX_COUNT = 8;
  localparam int ST_TX_COUNT = 16;
  localparam int ST_COUNT_W  = 5;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_TXDATA,
    REG_RXDATA,
    REG_SCRATCH,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [7:0] offset);
    case (offset)
      OFF_CTRL:    return REG_CTRL;
      OFF_STATUS:  return REG_STATUS;
      OFF_TXDATA:  return REG_TXDATA;
      OFF_RXDATA:  return REG_RXDATA;
      OFF_SCRATCH: return REG_SCRATCH;
      default:     return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Synchronous word FIFO with flush; full/empty are judged on current state, so a
// push into a full FIFO or a pop from an empty one is refused regardless of the other side.
module mbox_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Empty head reads as zero so the user side never sees stale or unreset storage.
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/user_wb_mailbox.sv
// Wishbone classic responder exposing a TX/RX word mailbox, CTRL/STATUS/SCRATCH
// registers and a registered level interrupt for the management core.
module user_wb_mailbox
  import user_wb_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              core_clk,
  input  logic              core_rstn,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_ack_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e          reg_sel;
  logic              hit;
  logic              rd_hit;
  logic              wr_hit;
  logic              tx_push;
  logic              rx_pop;
  logic              ctrl_wr;
  logic              status_wr;
  logic              scratch_wr;

  logic              rx_irq_en;
  logic              tx_irq_en;
  logic              tx_flush_q;
  logic              rx_flush_q;
  logic              tx_overflow;
  logic              rx_underflow;
  logic [DATA_W-1:0] scratch;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_data;

  logic              tx_full;
  logic              tx_empty;
  logic [CW-1:0]     tx_count;
  logic              rx_full;
  logic              rx_empty;
  logic [CW-1:0]     rx_count;
  logic [DATA_W-1:0] rx_head;

  // Masking with the registered ack makes every access take exactly one side effect.
  assign hit        = wb_cyc_i && wb_stb_i && (wb_adr_i[31:8] == BASE_ADDR[31:8]) && !wb_ack_o;
  assign reg_sel    = decode_offset(wb_adr_i[7:0]);
  assign rd_hit     = hit && !wb_we_i;
  assign wr_hit     = hit && wb_we_i;
  assign tx_push    = wr_hit && (reg_sel == REG_TXDATA);
  assign rx_pop     = rd_hit && (reg_sel == REG_RXDATA);
  assign ctrl_wr    = wr_hit && (reg_sel == REG_CTRL) && wb_sel_i[0];
  assign status_wr  = wr_hit && (reg_sel == REG_STATUS) && wb_sel_i[0];
  assign scratch_wr = wr_hit && (reg_sel == REG_SCRATCH);

  mbox_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
    .clk   (core_clk),
    .rst_n (core_rstn),
    .push  (tx_push),
    .pop   (tx_ready),
    .flush (tx_flush_q),
    .din   (wb_dat_i),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_data)
  );

  mbox_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
    .clk   (core_clk),
    .rst_n (core_rstn),
    .push  (rx_valid),
    .pop   (rx_pop),
    .flush (rx_flush_q),
    .din   (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    status                                = '0;
    status[ST_RX_EMPTY]                   = rx_empty;
    status[ST_RX_FULL]                    = rx_full;
    status[ST_TX_EMPTY]                   = tx_empty;
    status[ST_TX_FULL]                    = tx_full;
    status[ST_TX_OVF]                     = tx_overflow;
    status[ST_RX_UNF]                     = rx_underflow;
    status[ST_RX_COUNT +: ST_COUNT_W]     = ST_COUNT_W'(rx_count);
    status[ST_TX_COUNT +: ST_COUNT_W]     = ST_COUNT_W'(tx_count);
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL: begin
        rd_data[CTRL_RX_IRQ_EN] = rx_irq_en;
        rd_data[CTRL_TX_IRQ_EN] = tx_irq_en;
      end
      REG_STATUS:  rd_data = status;
      REG_RXDATA:  rd_data = rx_head;
      REG_SCRATCH: rd_data = scratch;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= hit;
      wb_dat_o <= rd_hit ? rd_data : '0;
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      rx_irq_en    <= 1'b0;
      tx_irq_en    <= 1'b0;
      tx_flush_q   <= 1'b0;
      rx_flush_q   <= 1'b0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      scratch      <= '0;
      irq_o        <= 1'b0;
    end else begin
      // Flush requests are one-cycle pulses; they never read back as set.
      tx_flush_q <= ctrl_wr && wb_dat_i[CTRL_TX_FLUSH];
      rx_flush_q <= ctrl_wr && wb_dat_i[CTRL_RX_FLUSH];
      if (ctrl_wr) begin
        rx_irq_en <= wb_dat_i[CTRL_RX_IRQ_EN];
        tx_irq_en <= wb_dat_i[CTRL_TX_IRQ_EN];
      end

      if (tx_push && tx_full)                         tx_overflow <= 1'b1;
      else if (status_wr && wb_dat_i[ST_TX_OVF])      tx_overflow <= 1'b0;

      if (rx_pop && rx_empty)                         rx_underflow <= 1'b1;
      else if (status_wr && wb_dat_i[ST_RX_UNF])      rx_underflow <= 1'b0;

      for (int b = 0; b < 4; b++) begin
        if (scratch_wr && wb_sel_i[b]) scratch[8*b +: 8] <= wb_dat_i[8*b +: 8];
      end

      irq_o <= (rx_irq_en && !rx_empty) || (tx_irq_en && tx_empty) ||
               tx_overflow || rx_underflow;
    end
  end

endmodule

// File: tb/tb_user_wb_mailbox.sv
// Self-checking bench for user_wb_mailbox: directed scenarios plus a randomized
// mix of firmware and user-side traffic checked against a queue-based model.
module tb_user_wb_mailbox;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 8;

  logic        core_clk  = 1'b0;
  logic        core_rstn = 1'b1;
  logic        wb_cyc_i  = 1'b0;
  logic        wb_stb_i  = 1'b0;
  logic        wb_we_i   = 1'b0;
  logic [3:0]  wb_sel_i  = 4'h0;
  logic [31:0] wb_adr_i  = '0;
  logic [31:0] wb_dat_i  = '0;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready  = 1'b0;
  logic        rx_valid  = 1'b0;
  logic [31:0] rx_data   = '0;
  logic        rx_ready;
  logic        irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit          m_rx_ie, m_tx_ie, m_ovf, m_unf;
  logic [31:0] m_scratch;

  user_wb_mailbox #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .core_clk  (core_clk),
    .core_rstn (core_rstn),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_sel_i  (wb_sel_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_o  (wb_ack_o),
    .wb_dat_o  (wb_dat_o),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .irq_o     (irq_o)
  );

  always #5 core_clk = ~core_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge core_clk);
    #1;
  endtask

  task automatic model_reset;
    tx_q.delete();
    rx_q.delete();
    m_rx_ie   = 0;
    m_tx_ie   = 0;
    m_ovf     = 0;
    m_unf     = 0;
    m_scratch = '0;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (rx_q.size() == 0);
    s[1]     = (rx_q.size() == DEPTH);
    s[2]     = (tx_q.size() == 0);
    s[3]     = (tx_q.size() == DEPTH);
    s[4]     = m_ovf;
    s[5]     = m_unf;
    s[12:8]  = 5'(rx_q.size());
    s[20:16] = 5'(tx_q.size());
    return s;
  endfunction

  function automatic logic m_irq();
    return (m_rx_ie && rx_q.size() != 0) || (m_tx_ie && tx_q.size() == 0) || m_ovf || m_unf;
  endfunction

  // One Wishbone access, optionally with a user RX push in the same cycle.
  task automatic fw_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit upush, input logic [31:0] udata,
                           input string name);
    logic [31:0] exp_rd;
    logic [7:0]  off;
    bit          hit;
    int          pre_rx;
    hit    = (adr[31:8] == BASE[31:8]);
    off    = adr[7:0];
    pre_rx = rx_q.size();
    exp_rd = '0;
    if (upush) begin
      n_cmp++;
      if (rx_ready !== (pre_rx < DEPTH)) begin
        n_bad++;
        $display("FAIL %s rx_ready: got %b want %b", name, rx_ready, pre_rx < DEPTH);
      end
    end
    if (hit && !we) begin
      case (off)
        8'h00: exp_rd = {30'b0, m_tx_ie, m_rx_ie};
        8'h04: exp_rd = m_status();
        8'h0C: if (pre_rx > 0) exp_rd = rx_q.pop_front(); else m_unf = 1;
        8'h10: exp_rd = m_scratch;
        default: exp_rd = '0;
      endcase
    end else if (hit) begin
      case (off)
        8'h00: if (sel[0]) begin
          m_rx_ie = dat[0];
          m_tx_ie = dat[1];
          if (dat[2]) tx_q.delete();
          if (dat[3]) rx_q.delete();
        end
        8'h04: if (sel[0]) begin
          if (dat[4]) m_ovf = 0;
          if (dat[5]) m_unf = 0;
        end
        8'h08: if (tx_q.size() == DEPTH) m_ovf = 1; else tx_q.push_back(dat);
        8'h10: for (int b = 0; b < 4; b++) if (sel[b]) m_scratch[8*b +: 8] = dat[8*b +: 8];
        default: ;
      endcase
    end
    if (upush && pre_rx < DEPTH) rx_q.push_back(udata);

    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    rx_valid = upush; rx_data = udata;
    step;
    rx_valid = 0;
    n_cmp++;
    if (wb_ack_o !== hit) begin
      n_bad++;
      $display("FAIL %s ack: got %b want %b", name, wb_ack_o, hit);
    end
    if (hit) begin
      n_cmp++;
      if (wb_dat_o !== exp_rd) begin
        n_bad++;
        $display("FAIL %s data: got %h want %h", name, wb_dat_o, exp_rd);
      end
    end
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    step;
    n_cmp++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      n_bad++;
      $display("FAIL %s ack_drop: got ack=%b dat=%h want ack=0 dat=0", name, wb_ack_o, wb_dat_o);
    end
  endtask

  task automatic check_irq(input string name);
    step;
    n_cmp++;
    if (irq_o !== m_irq()) begin
      n_bad++;
      $display("FAIL %s irq: got %b want %b", name, irq_o, m_irq());
    end
  endtask

  task automatic user_tx_pop(input string name);
    logic [31:0] exp_d;
    exp_d = (tx_q.size() != 0) ? tx_q[0] : 32'h0;
    n_cmp++;
    if (tx_valid !== (tx_q.size() != 0) || tx_data !== exp_d) begin
      n_bad++;
      $display("FAIL %s tx_head: got v=%b d=%h want v=%b d=%h", name, tx_valid, tx_data,
               tx_q.size() != 0, exp_d);
    end
    tx_ready = 1;
    step;
    tx_ready = 0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
  endtask

  task automatic user_rx_push(input logic [31:0] d, input string name);
    n_cmp++;
    if (rx_ready !== (rx_q.size() < DEPTH)) begin
      n_bad++;
      $display("FAIL %s rx_ready: got %b want %b", name, rx_ready, rx_q.size() < DEPTH);
    end
    rx_valid = 1; rx_data = d;
    step;
    rx_valid = 0;
    if (rx_q.size() < DEPTH) rx_q.push_back(d);
  endtask

  task automatic test_reset;
    #2 core_rstn = 0;
    model_reset();
    step; step;
    n_cmp++;
    if ({wb_ack_o, tx_valid, rx_ready, irq_o} !== 4'b0010 || wb_dat_o !== 0 || tx_data !== 0) begin
      n_bad++;
      $display("FAIL reset_values: got ack=%b txv=%b rxr=%b irq=%b dat=%h txd=%h want 0 0 1 0 0 0",
               wb_ack_o, tx_valid, rx_ready, irq_o, wb_dat_o, tx_data);
    end
    core_rstn = 1;
    step;
    fw_access(0, BASE + 32'h04, 0, 4'hF, 0, 0, "reset_status");
    check_irq("reset_irq");
  endtask

  task automatic test_tx_fill;
    for (int i = 1; i <= 8; i++) fw_access(1, BASE + 32'h08, 32'h11 * i, 4'hF, 0, 0, "tx_write");
    fw_access(1, BASE + 32'h08, 32'h99, 4'hF, 0, 0, "tx_write_overflow");
    fw_access(0, BASE + 32'h04, 0, 4'hF, 0, 0, "tx_full_status");
    tx_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 32'h11 * i) begin
        n_bad++;
        $display("FAIL tx_drain: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, 32'h11 * i);
      end
      step;
      void'(tx_q.pop_front());
    end
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_drained_valid: got %b want 0", tx_valid);
    end
    tx_ready = 0;
    fw_access(1, BASE + 32'h04, 32'h10, 4'hF, 0, 0, "w1c_ovf");
    fw_access(0, BASE + 32'h04, 0, 4'hF, 0, 0, "status_after_w1c");
    check_irq("tx_fill_irq");
  endtask

  task automatic test_rx_irq;
    fw_access(1, BASE, 32'h1, 4'hF, 0, 0, "ctrl_rx_ie");
    check_irq("rx_ie_empty_irq");
    user_rx_push(32'hA5A5_0001, "rx_push");
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_early: got %b want 0", irq_o);
    end
    step;
    n_cmp++;
    if (irq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_rise: got %b want 1", irq_o);
    end
    fw_access(0, BASE + 32'h0C, 0, 4'hF, 0, 0, "rxdata_pop");
    check_irq("irq_fall");
    fw_access(0, BASE + 32'h0C, 0, 4'hF, 0, 0, "rxdata_underflow");
    check_irq("irq_underflow");
    fw_access(1, BASE + 32'h04, 32'h20, 4'hF, 0, 0, "w1c_unf");
    fw_access(0, BASE + 32'h04, 0, 4'hF, 0, 0, "status_unf_clear");
    check_irq("irq_unf_clear");
    fw_access(1, BASE, 32'h0, 4'hF, 0, 0, "ctrl_off");
  endtask

  task automatic test_scratch_sel;
    fw_access(1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, "scratch_full");
    fw_access(1, BASE + 32'h10, 32'h0000_5500, 4'b0010, 0, 0, "scratch_lane1");
    fw_access(0, BASE + 32'h10, 0, 4'hF, 0, 0, "scratch_read");
    fw_access(0, 32'h3000_0100, 0, 4'hF, 0, 0, "miss_above");
    fw_access(1, 32'h2FFF_FF00, 32'h1234, 4'hF, 0, 0, "miss_below");
    fw_access(0, BASE + 32'h10, 0, 4'hF, 0, 0, "scratch_after_miss");
  endtask

  task automatic test_back_to_back;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = BASE + 32'h10; wb_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step;
      n_cmp++;
      if (wb_ack_o !== (i % 2 == 0) || wb_dat_o !== ((i % 2 == 0) ? m_scratch : 32'h0)) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d: got ack=%b dat=%h want ack=%b", i, wb_ack_o, wb_dat_o, i % 2 == 0);
      end
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    step;
  endtask

  task automatic test_rx_concurrent;
    for (int i = 0; i < DEPTH; i++) user_rx_push($urandom, "rx_fill");
    fw_access(0, BASE + 32'h0C, 0, 4'hF, 1, $urandom, "full_push_pop");
    fw_access(0, BASE + 32'h04, 0, 4'hF, 0, 0, "status_count7");
    for (int i = 0; i < 3; i++) fw_access(0, BASE + 32'h0C, 0, 4'hF, 0, 0, "rx_drain3");
    fw_access(0, BASE + 32'h0C, 0, 4'hF, 1, $urandom, "mid_push_pop");
    fw_access(0, BASE + 32'h04, 0, 4'hF, 0, 0, "status_count4");
    for (int i = 0; i < 4; i++) fw_access(0, BASE + 32'h0C, 0, 4'hF, 0, 0, "rx_drain4");
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) fw_access(1, BASE + 32'h08, $urandom, 4'hF, 0, 0, "flush_txfill");
    for (int i = 0; i < 2; i++) user_rx_push($urandom, "flush_rxfill");
    fw_access(1, BASE, 32'hC, 4'h1, 0, 0, "ctrl_flush");
    check_irq("flush_irq");
    fw_access(0, BASE + 32'h04, 0, 4'hF, 0, 0, "status_flushed");
    fw_access(0, BASE, 0, 4'hF, 0, 0, "ctrl_readback");
  endtask

  task automatic test_random;
    logic [31:0] d;
    for (int it = 0; it < 300; it++) begin
      d = $urandom;
      case ($urandom_range(0, 10))
        0, 1: fw_access(1, BASE + 32'h08, d, 4'($urandom), 0, 0, "rnd_txdata");
        2:    fw_access(0, BASE + 32'h0C, 0, 4'hF, $urandom_range(0, 1), d, "rnd_rxdata");
        3:    fw_access(0, BASE + 32'h04, 0, 4'hF, 0, 0, "rnd_status");
        4:    fw_access(1, BASE + 32'h10, d, 4'($urandom), 0, 0, "rnd_scratch_wr");
        5:    fw_access(0, BASE + {24'h0, 6'($urandom_range(0, 63)), 2'b00}, 0, 4'hF, 0, 0, "rnd_read");
        6:    user_tx_pop("rnd_tx_pop");
        7, 8: user_rx_push(d, "rnd_rx_push");
        9:    fw_access(1, BASE, {28'h0, ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00, 2'($urandom)},
                        4'($urandom), 0, 0, "rnd_ctrl");
        default: fw_access(1, BASE + {24'h0, 6'($urandom_range(1, 63)), 2'b00}, d, 4'hF, 0, 0, "rnd_write");
      endcase
      check_irq("rnd_irq");
    end
  endtask

  task automatic test_reset_mid;
    fw_access(1, BASE + 32'h10, 32'h5A5A_5A5A, 4'hF, 0, 0, "pre_reset_scratch");
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = BASE + 32'h08;
    wb_dat_i = 32'hCAFE_0001; wb_sel_i = 4'hF;
    step;
    n_cmp++;
    if (wb_ack_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_ack: got %b want 1", wb_ack_o);
    end
    core_rstn = 0;
    #1;
    n_cmp++;
    if ({wb_ack_o, tx_valid, rx_ready, irq_o} !== 4'b0010 || wb_dat_o !== 0 || tx_data !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got ack=%b txv=%b rxr=%b irq=%b dat=%h txd=%h want 0 0 1 0 0 0",
               wb_ack_o, tx_valid, rx_ready, irq_o, wb_dat_o, tx_data);
    end
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    model_reset();
    step;
    core_rstn = 1;
    step;
    fw_access(0, BASE + 32'h04, 0, 4'hF, 0, 0, "reset_mid_status");
    fw_access(0, BASE + 32'h10, 0, 4'hF, 0, 0, "reset_mid_scratch");
    fw_access(0, BASE, 0, 4'hF, 0, 0, "reset_mid_ctrl");
  endtask

  initial begin
    test_reset();
    test_tx_fill();
    test_rx_irq();
    test_scratch_sel();
    test_back_to_back();
    test_rx_concurrent();
    test_flush();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/user_wb_mailbox.md
# user_wb_mailbox

Wishbone responder in the user project area that answers the management core's exported user-project bus (cyc/stb/we/sel/adr/dat, ack, data return). It provides a two-direction word mailbox: a TX FIFO written by firmware and drained by user logic, an RX FIFO filled by user logic and popped by firmware. It also provides a control/status register set and a level interrupt routed back onto one of the core's user IRQ lines.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, window base; decode compares wb_adr_i[31:8] with BASE_ADDR[31:8].
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..16.

Ports:
- core_clk  in  1  sole clock, all logic rising-edge.
- core_rstn  in  1  asynchronous, active-low reset.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic cycle, strobe, write.
- wb_sel_i  in  4  byte lanes.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_dat_o  out  32  read data, valid with ack.
- tx_valid  out  1  TX FIFO non-empty.
- tx_data  out  32  TX FIFO head.
- tx_ready  in  1  user logic pops TX head when tx_valid && tx_ready.
- rx_valid  in  1  user logic push request.
- rx_data  in  32  push data.
- rx_ready  out  1  = RX not full; push happens when rx_valid && rx_ready.
- irq_o  out  1  level interrupt, registered.

## Operation
- Hit = cyc && stb && adr[31:8]==BASE_ADDR[31:8] && !wb_ack_o. Misses are never acked; another responder owns them.
- Register map, offset = adr[7:0]:
  - 0x00 CTRL, RW, honors sel: bit0 rx_irq_en, bit1 tx_irq_en, bit2 tx_flush, bit3 rx_flush. Flush bits are self-clearing: they empty the FIFO the cycle after the write and read back 0.
  - 0x04 STATUS: RO except W1C on bits 4,5. bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 tx_overflow, bit5 rx_underflow, [12:8] rx_count, [20:16] tx_count.
  - 0x08 TXDATA, WO: pushes wb_dat_i, sel ignored. When full, data is dropped and tx_overflow is set. Reads return 0.
  - 0x0C RXDATA, RO: returns the RX head and pops it. When empty, returns 0 and sets rx_underflow. Writes are ignored.
  - 0x10 SCRATCH, RW, honors sel.
  - Other offsets: acked, read 0, write ignored.
- Each hit causes exactly one side effect (push/pop/W1C), applied on the hit cycle.
- irq_o next = (rx_irq_en && !rx_empty) || (tx_irq_en && tx_empty) || tx_overflow || rx_underflow.
- FIFOs: counts are 0..FIFO_DEPTH ($clog2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
- Simultaneous push and pop on one FIFO: both occur and the count is unchanged.
- Full/empty are evaluated on current-cycle state:
  - A push into a full FIFO is refused even if a pop occurs the same cycle.
  - A pop from an empty FIFO is refused even if a push occurs the same cycle.
- Flush takes priority over a same-cycle push/pop.

## Timing
- Ack latency 1: hit in cycle N gives wb_ack_o=1 and wb_dat_o valid in N+1. Ack then falls in N+2 even if stb is held, so back-to-back accesses ack every other cycle.
- wb_dat_o is registered. It is 0 whenever ack is low and for all write acks.
- The RX pop and TX push take effect at the N->N+1 edge.
  - STATUS read in N+1 reflects them.
  - User-side tx_valid rises in N+1 after a push into an empty TX FIFO.
- User pop/push are zero-latency handshakes. tx_data/tx_valid are combinational from FIFO state.
- irq_o follows its cause by one cycle.
- Reset values: wb_ack_o 0, wb_dat_o 0, tx_valid 0, tx_data 0, rx_ready 1, irq_o 0, CTRL 0, SCRATCH 0, sticky bits 0, FIFOs empty.
- Reset asserted mid-transaction drops ack asynchronously. The master must reissue; no side effect survives.

## Structure
- Package user_wb_mailbox_pkg holds the register offset localparams (CTRL/STATUS/TXDATA/RXDATA/SCRATCH), CTRL/STATUS bit indices, and the width constant 32.
- Sub-module mbox_fifo (DEPTH, WIDTH; push/pop/flush, full/empty/count, head data) is instantiated twice.
- Top level contains decode, ack register, CSRs, and IRQ.

## Test plan
- Reset, then read STATUS at 0x3000_0004: ack exactly one cycle after stb; data 0x0000_0005 (rx_empty, tx_empty); irq_o 0.
- Write 0x11..0x88 (8 words) to TXDATA, then a 9th word 0x99: tx_full=1, tx_count=8, tx_overflow=1. User pops all 8 with tx_ready held: tx_data sequence 0x11..0x88, then tx_valid 0.
- User pushes 0xA5A5_0001 with rx_irq_en=1: irq_o rises 1 cycle later. Read RXDATA returns 0xA5A5_0001, irq_o falls. A second RXDATA read returns 0 and sets rx_underflow; W1C 0x20 to STATUS clears it.
- Write SCRATCH 0xDEAD_BEEF, then with sel=4'b0010 write 0x0000_5500: readback 0xDEAD_55EF. An access at 0x3000_0100 or 0x2FFF_FF00 gets no ack.
- RX FIFO at 8 entries: user push and firmware RXDATA pop in the same cycle, push refused (rx_ready=0), count ends at 7. At 4 entries with a simultaneous push and pop, count stays at 4.
- Assert core_rstn low in the ack cycle of a TXDATA write: ack drops immediately, tx_count 0, all outputs at reset values.
